// File: rtl/pmp_region_unit.sv
// Programmable memory-protection checker: NUM_REGIONS lockable base/limit/RWX entries, lowest index wins.
// One-cycle registered response with sticky fault capture; no backpressure, one request per cycle.
module pmp_region_unit #(
  parameter int         ADDR_W       = 8,
  parameter int         NUM_REGIONS  = 4,
  parameter logic [2:0] DEFAULT_PERM = 3'b000,
  parameter int         IDX_W        = $clog2(NUM_REGIONS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_limit,
  input  logic [2:0]        cfg_perm,
  input  logic              cfg_en,
  input  logic              cfg_lock,
  output logic              cfg_err,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_read,
  input  logic              req_write,
  input  logic              req_exec,
  output logic              resp_valid,
  output logic              resp_granted,
  output logic [IDX_W-1:0]  resp_region,
  output logic              fault_valid,
  output logic [ADDR_W-1:0] fault_addr,
  output logic [2:0]        fault_type,
  output logic [IDX_W-1:0]  fault_region,
  output logic [7:0]        fault_count,
  input  logic              fault_clear
);

  typedef struct packed {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] limit;
    logic [2:0]        perm;
    logic              en;
    logic              lock;
  } region_t;

  localparam logic [IDX_W-1:0] NO_HIT = IDX_W'(NUM_REGIONS);

  region_t          tbl [NUM_REGIONS];

  logic             hit_found;
  logic [IDX_W-1:0] hit_idx;
  logic [2:0]       hit_perm;
  logic [2:0]       need;
  logic             grant_c;
  logic             deny_c;
  logic             cfg_idx_ok;
  logic             cfg_locked;
  logic             cfg_reject;

  // Lowest-index enabled entry containing the address decides; base>limit can never contain it.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = NO_HIT;
    hit_perm  = DEFAULT_PERM;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (!hit_found && tbl[i].en && (tbl[i].base <= req_addr) && (req_addr <= tbl[i].limit)) begin
        hit_found = 1'b1;
        hit_idx   = IDX_W'(i);
        hit_perm  = tbl[i].perm;
      end
    end
  end

  assign need    = {req_exec, req_write, req_read};
  assign grant_c = ((need & ~hit_perm) == 3'b000);
  assign deny_c  = req_valid && !grant_c;

  always_comb begin
    cfg_locked = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if ((int'(cfg_idx) == i) && tbl[i].lock) cfg_locked = 1'b1;
    end
  end

  assign cfg_idx_ok = (int'(cfg_idx) < NUM_REGIONS);
  assign cfg_reject = cfg_we && (!cfg_idx_ok || cfg_locked);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGIONS; i++) tbl[i] <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_reject;
      if (cfg_we && !cfg_reject) begin
        for (int i = 0; i < NUM_REGIONS; i++) begin
          if (int'(cfg_idx) == i) begin
            tbl[i] <= '{base: cfg_base, limit: cfg_limit, perm: cfg_perm, en: cfg_en, lock: cfg_lock};
          end
        end
      end
    end
  end

  // Grant/region hold their last value on idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid   <= 1'b0;
      resp_granted <= 1'b0;
      resp_region  <= '0;
    end else begin
      resp_valid <= req_valid;
      if (req_valid) begin
        resp_granted <= grant_c;
        resp_region  <= hit_idx;
      end
    end
  end

  // Clear takes effect first, so a denial in the same cycle starts a fresh record.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_valid  <= 1'b0;
      fault_addr   <= '0;
      fault_type   <= '0;
      fault_region <= '0;
      fault_count  <= '0;
    end else begin
      if (fault_clear) begin
        fault_valid <= 1'b0;
        fault_count <= '0;
      end
      if (deny_c) begin
        if (!fault_valid || fault_clear) begin
          fault_valid  <= 1'b1;
          fault_addr   <= req_addr;
          fault_type   <= need;
          fault_region <= hit_idx;
          fault_count  <= 8'd1;
        end else if (fault_count != 8'hFF) begin
          fault_count <= fault_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pmp_region_unit.sv
// Directed table-driven bench for pmp_region_unit plus hand sequences for fault capture and reset.
module tb_pmp_region_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_we;
  logic [2:0] cfg_idx;
  logic [7:0] cfg_base, cfg_limit;
  logic [2:0] cfg_perm;
  logic       cfg_en, cfg_lock, cfg_err;
  logic       req_valid;
  logic [7:0] req_addr;
  logic       req_read, req_write, req_exec;
  logic       resp_valid, resp_granted;
  logic [2:0] resp_region;
  logic       fault_valid;
  logic [7:0] fault_addr;
  logic [2:0] fault_type, fault_region;
  logic [7:0] fault_count;
  logic       fault_clear;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pmp_region_unit dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_base(cfg_base), .cfg_limit(cfg_limit),
    .cfg_perm(cfg_perm), .cfg_en(cfg_en), .cfg_lock(cfg_lock), .cfg_err(cfg_err),
    .req_valid(req_valid), .req_addr(req_addr), .req_read(req_read),
    .req_write(req_write), .req_exec(req_exec),
    .resp_valid(resp_valid), .resp_granted(resp_granted), .resp_region(resp_region),
    .fault_valid(fault_valid), .fault_addr(fault_addr), .fault_type(fault_type),
    .fault_region(fault_region), .fault_count(fault_count), .fault_clear(fault_clear)
  );

  typedef struct {
    logic       rst;
    logic       we;
    logic [2:0] idx;
    logic [7:0] base, limit;
    logic [2:0] perm;
    logic       en, lock;
    logic       rv;
    logic [7:0] addr;
    logic [2:0] typ;   // {exec,write,read}
    logic       e_gnt;
    logic [2:0] e_reg;
    logic       e_err;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t blank();
    vec_t v;
    v.rst = 0; v.we = 0; v.idx = 0; v.base = 0; v.limit = 0; v.perm = 0; v.en = 0;
    v.lock = 0; v.rv = 0; v.addr = 0; v.typ = 0; v.e_gnt = 0; v.e_reg = 0; v.e_err = 0;
    return v;
  endfunction

  function automatic vec_t mk_rst();
    vec_t v = blank();
    v.rst = 1;
    return v;
  endfunction

  function automatic vec_t mk_cfg(logic [2:0] idx, logic [7:0] b, logic [7:0] l,
                                  logic [2:0] p, logic en, logic lock, logic err);
    vec_t v = blank();
    v.we = 1; v.idx = idx; v.base = b; v.limit = l; v.perm = p; v.en = en; v.lock = lock;
    v.e_err = err;
    return v;
  endfunction

  function automatic vec_t mk_req(logic [7:0] a, logic [2:0] typ, logic gnt, logic [2:0] rg);
    vec_t v = blank();
    v.rv = 1; v.addr = a; v.typ = typ; v.e_gnt = gnt; v.e_reg = rg;
    return v;
  endfunction

  task automatic chk(string nm, int n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", nm, n, act, exp);
    end
  endtask

  task automatic idle();
    reset = 0; cfg_we = 0; cfg_idx = 0; cfg_base = 0; cfg_limit = 0; cfg_perm = 0;
    cfg_en = 0; cfg_lock = 0; req_valid = 0; req_addr = 0; req_read = 0;
    req_write = 0; req_exec = 0; fault_clear = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(logic [7:0] a, logic [2:0] typ);
    req_valid = 1; req_addr = a; {req_exec, req_write, req_read} = typ;
  endtask

  initial begin
    idle();
    reset = 1;
    tick();

    tv.push_back(mk_rst());
    tv.push_back(mk_req(8'h10, 3'b001, 0, 3'd4));
    // Disjoint regions
    tv.push_back(mk_cfg(0, 8'h00, 8'h3F, 3'b111, 1, 0, 0));
    tv.push_back(mk_cfg(1, 8'h40, 8'h7F, 3'b101, 1, 0, 0));
    tv.push_back(mk_req(8'h50, 3'b010, 0, 3'd1));
    tv.push_back(mk_req(8'h50, 3'b001, 1, 3'd1));
    tv.push_back(mk_req(8'h3F, 3'b100, 1, 3'd0));
    tv.push_back(mk_req(8'hC0, 3'b001, 0, 3'd4));
    tv.push_back(mk_req(8'hC0, 3'b000, 1, 3'd4));
    // Overlap priority
    tv.push_back(mk_cfg(0, 8'h00, 8'h7F, 3'b000, 1, 0, 0));
    tv.push_back(mk_cfg(1, 8'h00, 8'hFF, 3'b111, 1, 0, 0));
    tv.push_back(mk_req(8'h20, 3'b001, 0, 3'd0));
    tv.push_back(mk_req(8'h90, 3'b001, 1, 3'd1));
    // Inverted range never hits; disabled entry ignored
    tv.push_back(mk_cfg(2, 8'h90, 8'h80, 3'b111, 1, 0, 0));
    tv.push_back(mk_cfg(1, 8'h00, 8'hFF, 3'b111, 0, 0, 0));
    tv.push_back(mk_req(8'h85, 3'b001, 0, 3'd4));
    tv.push_back(mk_req(8'h90, 3'b001, 0, 3'd4));
    // Locking
    tv.push_back(mk_cfg(0, 8'h00, 8'h7F, 3'b000, 0, 0, 0));
    tv.push_back(mk_cfg(1, 8'h10, 8'h1F, 3'b011, 1, 1, 0));
    tv.push_back(mk_cfg(1, 8'h00, 8'hFF, 3'b111, 1, 0, 1));
    tv.push_back(mk_cfg(1, 8'h10, 8'h1F, 3'b011, 0, 1, 1));
    tv.push_back(mk_req(8'h15, 3'b010, 1, 3'd1));
    tv.push_back(mk_req(8'h15, 3'b100, 0, 3'd1));
    tv.push_back(mk_req(8'h20, 3'b001, 0, 3'd4));
    tv.push_back(mk_cfg(5, 8'h00, 8'hFF, 3'b111, 1, 0, 1));
    tv.push_back(mk_cfg(4, 8'h00, 8'hFF, 3'b111, 1, 0, 1));
    tv.push_back(mk_rst());
    tv.push_back(mk_cfg(1, 8'h00, 8'hFF, 3'b111, 1, 0, 0));
    tv.push_back(mk_req(8'h20, 3'b100, 1, 3'd1));
    // Same-cycle write and request sees the old table
    tv.push_back(mk_rst());
    begin
      vec_t v = mk_cfg(0, 8'h00, 8'hFF, 3'b111, 1, 0, 0);
      v.rv = 1; v.addr = 8'h00; v.typ = 3'b001; v.e_gnt = 0; v.e_reg = 3'd4;
      tv.push_back(v);
    end
    tv.push_back(mk_req(8'h00, 3'b001, 1, 3'd0));

    foreach (tv[n]) begin
      idle();
      reset = tv[n].rst;
      cfg_we = tv[n].we; cfg_idx = tv[n].idx; cfg_base = tv[n].base; cfg_limit = tv[n].limit;
      cfg_perm = tv[n].perm; cfg_en = tv[n].en; cfg_lock = tv[n].lock;
      if (tv[n].rv) drive_req(tv[n].addr, tv[n].typ);
      tick();
      chk("resp_valid", n, 32'(resp_valid), 32'(tv[n].rv && !tv[n].rst));
      chk("cfg_err", n, 32'(cfg_err), 32'(tv[n].e_err));
      if (tv[n].rv || tv[n].rst) begin
        chk("resp_granted", n, 32'(resp_granted), 32'(tv[n].e_gnt));
        chk("resp_region", n, 32'(resp_region), 32'(tv[n].e_reg));
      end
      if (tv[n].rst) begin
        chk("rst_fault_valid", n, 32'(fault_valid), 32'd0);
        chk("rst_fault_count", n, 32'(fault_count), 32'd0);
      end
    end

    // First denial after reset captures a record
    idle(); reset = 1; tick();
    idle(); drive_req(8'h10, 3'b001); tick();
    chk("t1_resp_valid", 100, 32'(resp_valid), 32'd1);
    chk("t1_granted", 100, 32'(resp_granted), 32'd0);
    chk("t1_region", 100, 32'(resp_region), 32'd4);
    chk("t1_fault_valid", 100, 32'(fault_valid), 32'd1);
    chk("t1_fault_addr", 100, 32'(fault_addr), 32'h10);
    chk("t1_fault_type", 100, 32'(fault_type), 32'b001);
    chk("t1_fault_region", 100, 32'(fault_region), 32'd4);
    chk("t1_fault_count", 100, 32'(fault_count), 32'd1);
    idle(); tick();
    chk("hold_valid", 101, 32'(resp_valid), 32'd0);
    chk("hold_granted", 101, 32'(resp_granted), 32'd0);
    chk("hold_region", 101, 32'(resp_region), 32'd4);

    // Back-to-back denials, clear, clear with coincident denial
    idle(); reset = 1; tick();
    idle(); drive_req(8'h80, 3'b001); tick();
    idle(); drive_req(8'h81, 3'b010); tick();
    idle(); drive_req(8'h82, 3'b100); tick();
    chk("b2b_resp_valid", 200, 32'(resp_valid), 32'd1);
    chk("b2b_fault_addr", 200, 32'(fault_addr), 32'h80);
    chk("b2b_fault_type", 200, 32'(fault_type), 32'b001);
    chk("b2b_fault_count", 200, 32'(fault_count), 32'd3);
    idle(); drive_req(8'h83, 3'b000); tick();
    chk("notype_granted", 201, 32'(resp_granted), 32'd1);
    chk("notype_count", 201, 32'(fault_count), 32'd3);
    idle(); fault_clear = 1; tick();
    chk("clr_valid", 202, 32'(fault_valid), 32'd0);
    chk("clr_count", 202, 32'(fault_count), 32'd0);
    chk("clr_addr_kept", 202, 32'(fault_addr), 32'h80);
    idle(); drive_req(8'h50, 3'b001); tick();
    idle(); fault_clear = 1; drive_req(8'h90, 3'b010); tick();
    chk("clrcap_valid", 203, 32'(fault_valid), 32'd1);
    chk("clrcap_addr", 203, 32'(fault_addr), 32'h90);
    chk("clrcap_type", 203, 32'(fault_type), 32'b010);
    chk("clrcap_count", 203, 32'(fault_count), 32'd1);
    for (int k = 0; k < 260; k++) begin
      idle(); drive_req(8'(k), 3'b001); tick();
    end
    chk("sat_count", 204, 32'(fault_count), 32'hFF);
    chk("sat_addr", 204, 32'(fault_addr), 32'h90);

    // Reset coinciding with a request discards it
    idle(); reset = 1; drive_req(8'h10, 3'b001); tick();
    chk("rstreq_resp_valid", 300, 32'(resp_valid), 32'd0);
    chk("rstreq_fault_valid", 300, 32'(fault_valid), 32'd0);
    chk("rstreq_fault_count", 300, 32'(fault_count), 32'd0);
    idle(); tick();
    chk("rstreq_after_valid", 301, 32'(resp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
